// File: rtl/mips_pkg.sv
// Shared MIPS-datapath constants: ALU control codes, multiplier widths and
// the multiply sequencer state encoding.
package mips_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_NEG_A  = 3'd1;
    localparam logic [2:0] ST_NEG_B  = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_FIX_LO = 3'd4;
    localparam logic [2:0] ST_FIX_HI = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_NEG_A  = ST_NEG_A,
        S_NEG_B  = ST_NEG_B,
        S_RUN    = ST_RUN,
        S_FIX_LO = ST_FIX_LO,
        S_FIX_HI = ST_FIX_HI,
        S_DONE   = ST_DONE
    } mult_state_e;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Request/result handshake plus the borrowed-ALU port of the multiply sequencer.
interface mult_seq_ctrl_if;
    import mips_pkg::*;

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             alu_own;
    logic [2:0]       alu_ctl;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    modport master (
        output start, is_signed, op_a, op_b,
        input  busy, done, hi, lo,
        input  alu_own, alu_ctl, alu_a, alu_b,
        output alu_result, alu_zero
    );

    modport slave (
        input  start, is_signed, op_a, op_b,
        output busy, done, hi, lo,
        output alu_own, alu_ctl, alu_a, alu_b,
        input  alu_result, alu_zero
    );

endinterface

// File: rtl/ALU_32bits.sv
// Shared 32-bit datapath ALU: AND/OR/ADD/SUB/SLT with a zero flag, purely combinational.
module ALU_32bits
    import mips_pkg::*;
(
    input  logic [2:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    always_comb begin
        result = '0;
        case (ctl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Shift-add MULT/MULTU sequencer: borrows the shared ALU for one add (or negate)
// per cycle and leaves the 64-bit product in HI/LO.
module mult_seq_ctrl
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    mult_seq_ctrl_if.slave  bus
);

    mult_state_e      state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             lo_was_zero_q, lo_was_zero_d;
    logic             busy_q, done_q, alu_own_q;
    logic [2:0]       alu_ctl_d;
    logic [WIDTH-1:0] alu_a_d, alu_b_d;
    logic             carry;

    always_comb begin
        state_d       = state_q;
        mcand_d       = mcand_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        cnt_d         = cnt_q;
        neg_d         = neg_q;
        lo_was_zero_d = lo_was_zero_q;
        alu_ctl_d     = ALU_ADD;
        alu_a_d       = '0;
        alu_b_d       = '0;
        carry         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mcand_d = bus.op_a;
                    lo_d    = bus.op_b;
                    hi_d    = '0;
                    cnt_d   = '0;
                    neg_d   = bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                    state_d = bus.is_signed ? S_NEG_A : S_RUN;
                end
            end
            S_NEG_A: begin
                alu_ctl_d = ALU_SUB;
                alu_b_d   = mcand_q;
                if (mcand_q[WIDTH-1]) mcand_d = bus.alu_result;
                state_d   = S_NEG_B;
            end
            S_NEG_B: begin
                alu_ctl_d = ALU_SUB;
                alu_b_d   = lo_q;
                if (lo_q[WIDTH-1]) lo_d = bus.alu_result;
                state_d   = S_RUN;
            end
            S_RUN: begin
                alu_a_d = hi_q;
                alu_b_d = lo_q[0] ? mcand_q : '0;
                // The ALU has no carry-out, so recover it from the operand and result MSBs.
                carry = (alu_a_d[WIDTH-1] & alu_b_d[WIDTH-1]) |
                        ((alu_a_d[WIDTH-1] | alu_b_d[WIDTH-1]) & ~bus.alu_result[WIDTH-1]);
                hi_d  = {carry, bus.alu_result[WIDTH-1:1]};
                lo_d  = {bus.alu_result[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1)) state_d = neg_q ? S_FIX_LO : S_DONE;
            end
            S_FIX_LO: begin
                alu_ctl_d     = ALU_SUB;
                alu_b_d       = lo_q;
                lo_d          = bus.alu_result;
                lo_was_zero_d = bus.alu_zero;
                state_d       = S_FIX_HI;
            end
            S_FIX_HI: begin
                // 64-bit negate: the +1 only ripples into HI when LO negated to zero.
                alu_ctl_d = ALU_SUB;
                alu_b_d   = hi_q;
                hi_d      = lo_was_zero_q ? bus.alu_result : ~hi_q;
                state_d   = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mcand_q       <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            cnt_q         <= '0;
            neg_q         <= 1'b0;
            lo_was_zero_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            alu_own_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            mcand_q       <= mcand_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            cnt_q         <= cnt_d;
            neg_q         <= neg_d;
            lo_was_zero_q <= lo_was_zero_d;
            busy_q        <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q        <= (state_d == S_DONE);
            alu_own_q     <= (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_RUN) ||
                             (state_d == S_RUN);
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.alu_own = alu_own_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.alu_ctl = alu_ctl_d;
    assign bus.alu_a   = alu_a_d;
    assign bus.alu_b   = alu_b_d;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl driving the real ALU_32bits on the borrowed-ALU port.
module tb_mult_seq_ctrl;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_seq_ctrl_if bus();

    mult_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ALU_32bits alu (
        .ctl    (bus.alu_ctl),
        .a      (bus.alu_a),
        .b      (bus.alu_b),
        .result (bus.alu_result),
        .zero   (bus.alu_zero)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
        string       name;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb;
        xa = s ? {{32{a[31]}}, a} : {32'b0, a};
        xb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return xa * xb;
    endfunction

    // Edge index (accepting edge = 0) at which done is sampled high.
    function automatic int latency(input logic s, input logic [31:0] a, input logic [31:0] b);
        if (!s) return 33;
        return (a[31] ^ b[31]) ? 37 : 35;
    endfunction

    // Called just after a negedge; holds start until busy shows the request was taken.
    task automatic accept(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input int n,
                          input string name);
        exp_t e;
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.op_a      = a;
        bus.op_b      = b;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (bus.busy) break;
        end
        bus.start = 1'b0;
        chk({name, ".accept"}, {63'b0, bus.busy}, 64'd1);
        e.hi = hi; e.lo = lo; e.n = n; e.name = name;
        sb.push_back(e);
    endtask

    // Starts at negedge idx=1 after the accepting edge; returns at the negedge where done is high.
    // A negedge with index idx samples the value that edge idx would see.
    task automatic wait_done(input int inj1, input int inj2);
        int   idx      = 1;
        int   busy_cnt = 0;
        bit   seen     = 0;
        exp_t e;
        while (idx <= 60) begin
            if (bus.done) begin
                seen = 1;
                break;
            end
            if (bus.busy) busy_cnt++;
            bus.start     = (idx == inj1) || (idx == inj2);
            bus.op_a      = $urandom;
            bus.op_b      = $urandom;
            bus.is_signed = 1'($urandom_range(0, 1));
            @(negedge clk);
            idx++;
        end
        bus.start = 1'b0;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        if (!seen) begin
            chk({e.name, ".timeout"}, 64'd1, 64'd0);
            return;
        end
        chk({e.name, ".hi"},      {32'b0, bus.hi}, {32'b0, e.hi});
        chk({e.name, ".lo"},      {32'b0, bus.lo}, {32'b0, e.lo});
        chk({e.name, ".done_at"}, 64'(idx), 64'(e.n));
        chk({e.name, ".busy_cycles"}, 64'(busy_cnt), 64'(e.n - 1));
        chk({e.name, ".busy_at_done"}, {63'b0, bus.busy}, 64'd0);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, ".busy"},    {63'b0, bus.busy},    64'd0);
        chk({name, ".done"},    {63'b0, bus.done},    64'd0);
        chk({name, ".alu_own"}, {63'b0, bus.alu_own}, 64'd0);
        chk({name, ".hi"},      {32'b0, bus.hi},      64'd0);
        chk({name, ".lo"},      {32'b0, bus.lo},      64'd0);
        chk({name, ".alu_ctl"}, {61'b0, bus.alu_ctl}, {61'b0, ALU_ADD});
        chk({name, ".alu_a"},   {32'b0, bus.alu_a},   64'd0);
        chk({name, ".alu_b"},   {32'b0, bus.alu_b},   64'd0);
    endtask

    vec_t vecs[$];

    initial begin
        vec_t        v;
        logic [63:0] p;
        int          done_seen;

        vecs.push_back('{1'b0, 32'd3,        32'd5,        32'h0,        32'h0000000F, 33, "multu_3x5"});
        vecs.push_back('{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, "multu_max"});
        vecs.push_back('{1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 37, "mult_m3x5"});
        vecs.push_back('{1'b1, 32'hFFFFFFFF, 32'd0,        32'h0,        32'h0,        37, "mult_m1x0"});
        vecs.push_back('{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        35, "mult_min"});
        vecs.push_back('{1'b1, 32'hFFFFFFF9, 32'hFFFFFFF7, 32'h0,        32'd63,       35, "mult_m7xm9"});
        vecs.push_back('{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 35, "mult_maxpos"});
        for (int i = 0; i < 4; i++) begin
            v.s  = 1'($urandom_range(0, 1));
            v.a  = $urandom;
            v.b  = $urandom;
            p    = model(v.s, v.a, v.b);
            v.hi = p[63:32];
            v.lo = p[31:0];
            v.n  = latency(v.s, v.a, v.b);
            v.name = $sformatf("rand%0d", i);
            vecs.push_back(v);
        end

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        #1;
        check_idle_outputs("reset_async");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset");

        foreach (vecs[i]) begin
            accept(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].n, vecs[i].name);
            wait_done(0, 0);
            @(negedge clk);
            chk({vecs[i].name, ".done_pulse"}, {63'b0, bus.done}, 64'd0);
        end

        // Stray starts while busy, then a restart requested while done is high.
        accept(1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 33, "busy_ignore");
        wait_done(5, 20);
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.op_a      = 32'd2;
        bus.op_b      = 32'd2;
        @(negedge clk);
        chk("restart.ignored_in_done", {63'b0, bus.busy}, 64'd0);
        chk("restart.single_done",     {63'b0, bus.done}, 64'd0);
        accept(1'b0, 32'd2, 32'd2, 32'd0, 32'd4, 33, "restart_2x2");
        wait_done(0, 0);
        @(negedge clk);

        // Reset in the middle of a multiply.
        accept(1'b0, 32'h11111111, 32'd3, 32'h0, 32'h33333333, 33, "rst_mid");
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_front());
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        chk("rst_mid.no_done", 64'(done_seen), 64'd0);
        accept(1'b0, 32'd9, 32'd9, 32'd0, 32'd81, 33, "after_rst_9x9");
        wait_done(0, 0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
